// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART message scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DEFAULT_DW = 8;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_GUARD   = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_t;

    // Source of the character currently being transmitted.
    typedef enum logic [1:0] {
        SEL_ECHO = 2'd0,
        SEL_BUF  = 2'd1,
        SEL_CR   = 2'd2,
        SEL_LF   = 2'd3
    } sel_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_echo_fifo.sv
// ============================================================================
// Module      : uart_echo_fifo
// Description : Synchronous echo FIFO with full/empty and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int DW         = DEFAULT_DW,
    parameter int ECHO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_overflow
);

    localparam int          AW      = clog2(ECHO_DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(ECHO_DEPTH);

    logic [DW-1:0] r_mem [ECHO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full     = (r_count == C_DEPTH);
    assign o_empty    = (r_count == '0);
    assign o_rdata    = r_mem[r_rptr];
    assign o_overflow = r_overflow;

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (i_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_msg_sched.sv
// ============================================================================
// Module      : uart_msg_sched
// Description : Periodic message transmitter with prioritised receive echo.
//               Optional CR/LF trailer enabled by macro UART_MSG_CRLF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_msg_sched
    import uart_pkg::*;
#(
    parameter int DW            = DEFAULT_DW,
    parameter int MSG_DEPTH     = 32,
    parameter int ECHO_DEPTH    = 4,
    parameter int PERIOD_CYCLES = 262144,
    parameter int GAP_CYCLES    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_valid,
    input  logic [DW-1:0]                rx_data,
    input  logic                         tx_busy,
    output logic                         tx_start,
    output logic [DW-1:0]                tx_data,
    input  logic                         msg_we,
    input  logic [$clog2(MSG_DEPTH)-1:0] msg_waddr,
    input  logic [DW-1:0]                msg_wdata,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    output logic                         msg_active,
    output logic                         echo_overflow
);

    localparam int MAW = clog2(MSG_DEPTH);
    localparam int PW  = clog2(PERIOD_CYCLES) + 1;
    localparam int GW  = clog2(GAP_CYCLES) + 1;

    localparam logic [PW-1:0] C_PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [GW-1:0] C_GAP_LAST    = GW'(GAP_CYCLES - 1);

`ifdef UART_MSG_CRLF_EN
    localparam bit CRLF_EN = 1'b1;
`else
    localparam bit CRLF_EN = 1'b0;
`endif

    logic [DW-1:0] r_buf [MSG_DEPTH];

    state_t        r_state;
    state_t        w_next;
    sel_t          r_sel;
    sel_t          r_phase;
    sel_t          w_sel;
    logic [DW-1:0] w_sel_data;
    logic [DW-1:0] r_tx_data;
    logic          r_tx_start;
    logic          r_msg_active;
    logic [MAW:0]  r_index;
    logic [PW-1:0] r_period;
    logic [GW-1:0] r_gap;

    logic          w_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [DW-1:0] w_fifo_rdata;
    logic          w_unused_full;
    logic          w_period_hit;
    logic          w_char_done;
    logic          w_buf_done;

    uart_echo_fifo #(
        .DW         (DW),
        .ECHO_DEPTH (ECHO_DEPTH)
    ) u_echo_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (rx_valid),
        .i_wdata    (rx_data),
        .i_pop      (w_pop),
        .o_rdata    (w_fifo_rdata),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_overflow (echo_overflow)
    );

    assign w_unused_full = w_fifo_full;

    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign msg_active = r_msg_active;

    assign w_period_hit = (r_period == C_PERIOD_LAST) && (msg_len != '0);
    assign w_char_done  = (r_state == ST_WAIT_TX) && !tx_busy && (r_sel != SEL_ECHO);
    // Compared against the live length so a shrink mid-message ends it early.
    assign w_buf_done   = (r_sel == SEL_BUF) && (r_index >= msg_len);

    always_ff @(posedge clk) begin
        if (msg_we) begin
            r_buf[msg_waddr] <= msg_wdata;
        end
    end

    always_comb begin
        w_sel      = r_phase;
        w_sel_data = r_buf[r_index[MAW-1:0]];
        if (!w_fifo_empty) begin
            w_sel      = SEL_ECHO;
            w_sel_data = w_fifo_rdata;
        end else if (r_phase == SEL_CR) begin
            w_sel_data = DW'(CHAR_CR);
        end else if (r_phase == SEL_LF) begin
            w_sel_data = DW'(CHAR_LF);
        end
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Holding off while busy protects a frame left running across rst.
                if (!tx_busy && (!w_fifo_empty || w_period_hit)) begin
                    w_next = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!w_fifo_empty || r_msg_active || w_period_hit) begin
                    w_next = ST_ISSUE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_GUARD;
                w_pop  = (r_sel == SEL_ECHO);
            end
            ST_GUARD: begin
                if (r_gap >= C_GAP_LAST) begin
                    w_next = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (!tx_busy) begin
                    w_next = ST_ARB;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_sel        <= SEL_ECHO;
            r_phase      <= SEL_BUF;
            r_msg_active <= 1'b0;
            r_index      <= '0;
            r_period     <= '0;
            r_gap        <= '0;
        end else begin
            r_tx_start <= (w_next == ST_ISSUE);
            if (!r_msg_active && (r_period != C_PERIOD_LAST)) begin
                r_period <= r_period + 1'b1;
            end
            case (r_state)
                ST_ARB: begin
                    if (w_next == ST_ISSUE) begin
                        r_sel     <= w_sel;
                        r_tx_data <= w_sel_data;
                        if ((w_sel != SEL_ECHO) && !r_msg_active) begin
                            r_msg_active <= 1'b1;
                            r_period     <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_gap <= GW'(1);
                    if (r_sel == SEL_BUF) begin
                        r_index <= r_index + 1'b1;
                    end
                end
                ST_GUARD: begin
                    r_gap <= r_gap + 1'b1;
                end
                ST_WAIT_TX: begin
                    if (w_char_done) begin
                        if (CRLF_EN && w_buf_done) begin
                            r_phase <= SEL_CR;
                        end else if (CRLF_EN && (r_sel == SEL_CR)) begin
                            r_phase <= SEL_LF;
                        end else if (w_buf_done || (r_sel == SEL_LF)) begin
                            r_phase      <= SEL_BUF;
                            r_index      <= '0;
                            r_msg_active <= 1'b0;
                            r_period     <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_msg_sched.sv
// ============================================================================
// Module      : tb_uart_msg_sched
// Description : Directed/randomised self-checking bench for uart_msg_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_msg_sched;

    localparam int DW         = 8;
    localparam int MSG_DEPTH  = 32;
    localparam int ECHO_DEPTH = 4;
    localparam int PERIOD     = 100;
    localparam int GAP        = 16;
    localparam int BUSY       = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       msg_we = 1'b0;
    logic [4:0] msg_waddr = '0;
    logic [7:0] msg_wdata = '0;
    logic [5:0] msg_len = '0;
    logic       msg_active;
    logic       echo_overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busy_cnt = 0;

    int         st_cyc [$];
    logic [7:0] st_data[$];
    logic       st_act [$];
    logic [7:0] msg [32];
    logic [7:0] exp_q [$];

    uart_msg_sched #(
        .DW            (DW),
        .MSG_DEPTH     (MSG_DEPTH),
        .ECHO_DEPTH    (ECHO_DEPTH),
        .PERIOD_CYCLES (PERIOD),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .msg_we        (msg_we),
        .msg_waddr     (msg_waddr),
        .msg_wdata     (msg_wdata),
        .msg_len       (msg_len),
        .msg_active    (msg_active),
        .echo_overflow (echo_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // tx core model: busy for BUSY cycles starting the cycle after tx_start
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= BUSY;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        if (tx_start) begin
            st_cyc.push_back(cyc);
            st_data.push_back(tx_data);
            st_act.push_back(msg_active);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sc(input int i);
        return (i < st_cyc.size()) ? st_cyc[i] : -1;
    endfunction

    function automatic logic [31:0] sd(input int i);
        return (i < st_data.size()) ? {24'h0, st_data[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic wait_starts(input int n, input int budget, input string tag);
        int b;
        b = budget;
        while (st_data.size() < n && b > 0) begin
            tick();
            b--;
        end
        check({tag, "_timeout"}, 32'(st_data.size() >= n), 32'd1);
    endtask

    task automatic program_msg(input int len);
        for (int i = 0; i < len; i++) begin
            msg_we    = 1'b1;
            msg_waddr = 5'(i);
            msg_wdata = msg[i];
            tick();
        end
        msg_we = 1'b0;
    endtask

    // Reference: buffer characters followed by the optional CR/LF trailer
    task automatic build_exp(input int len);
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(msg[i]);
`ifdef UART_MSG_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic send_rx(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        int base, base2, n, len, k, lst, fall, t0, nrx, d;
        logic [7:0] r, z, e;
        logic [7:0] b [6];
        logic [7:0] ref_q [$];

        rst = 1'b1;
        repeat (3) tick();
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_msg_active", 32'(msg_active), 32'd0);
        check("rst_overflow", 32'(echo_overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Message "Hello\n"
        msg[0] = 8'h48; msg[1] = 8'h65; msg[2] = 8'h6C;
        msg[3] = 8'h6C; msg[4] = 8'h6F; msg[5] = 8'h0A;
        program_msg(6);
        build_exp(6);
        n = exp_q.size();
        base = st_data.size();
        msg_len = 6'd6;
        wait_starts(base + n, 2000, "msg1");
        for (int i = 0; i < n; i++) check($sformatf("msg1_ch%0d", i), sd(base + i), 32'(exp_q[i]));
        check("msg1_active_ch0", 32'((base < st_act.size()) ? st_act[base] : 1'b0), 32'd1);
        // busy falls 21 cycles after start; WAIT_TX->ARB->ISSUE adds two
        check("msg1_spacing", 32'(sc(base + 1) - sc(base)), 32'(BUSY + 3));
        lst  = sc(base + n - 1);
        fall = lst + BUSY + 1;
        while (cyc < fall + 5) tick();
        check("msg1_active_end", 32'(msg_active), 32'd0);

        base2 = base + n;
        wait_starts(base2 + 1, 400, "msg2_start");
        d = sc(base2) - fall;
        check("msg2_period", 32'((d >= PERIOD) && (d <= PERIOD + 3)), 32'd1);

        // Echo 'A' injected right after 'e' is issued
        wait_starts(base2 + 2, 200, "msg2_e");
        send_rx(8'h41);
        wait_starts(base2 + n + 1, 1500, "msg2_all");
        msg_len = 6'd0;
        ref_q = exp_q;
        ref_q.insert(2, 8'h41);
        for (int i = 0; i < n + 1; i++) check($sformatf("msg2_ch%0d", i), sd(base2 + i), 32'(ref_q[i]));

        // Echo latency from idle
        repeat (40) tick();
        base = st_data.size();
        r = 8'($urandom);
        nrx = cyc;
        send_rx(r);
        wait_starts(base + 1, 50, "lat");
        check("lat_cycle", 32'(sc(base)), 32'(nrx + 3));
        check("lat_data", sd(base), 32'(r));

        // Six back-to-back bytes while the tx core is busy
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) send_rx(b[i]);
        tick();
        check("ovf_set", 32'(echo_overflow), 32'd1);
        wait_starts(base + 1 + ECHO_DEPTH, 600, "ovf_echo");
        for (int i = 0; i < ECHO_DEPTH; i++) check($sformatf("ovf_ch%0d", i), sd(base + 1 + i), 32'(b[i]));
        repeat (200) tick();
        check("ovf_count", 32'(st_data.size()), 32'(base + 1 + ECHO_DEPTH));
        check("ovf_sticky", 32'(echo_overflow), 32'd1);

        // msg_len=0 keeps the transmitter silent
        base = st_data.size();
        repeat (10 * PERIOD) tick();
        check("len0_silent", 32'(st_data.size()), 32'(base));

        // Reset while WAIT_TX with busy high
        len = $urandom_range(8, 3);
        for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
        program_msg(len);
        base = st_data.size();
        msg_len = 6'(len);
        wait_starts(base + 1, 400, "rst_msg");
        check("rst_msg_ch0", sd(base), 32'(msg[0]));
        t0 = sc(base);
        while (cyc < t0 + 18) tick();
        rst = 1'b1;
        msg_len = 6'd0;
        tick();
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_active", 32'(msg_active), 32'd0);
        check("mid_rst_overflow", 32'(echo_overflow), 32'd0);
        rst = 1'b0;
        z = 8'($urandom);
        send_rx(z);
        wait_starts(base + 2, 100, "rst_echo");
        // busy low at t0+21, then ARB and ISSUE
        check("rst_echo_cycle", 32'(sc(base + 1)), 32'(t0 + 23));
        check("rst_echo_data", sd(base + 1), 32'(z));

        // Random message with one echo interleaved at a random position
        repeat (30) tick();
        len = $urandom_range(7, 2);
        for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
        program_msg(len);
        build_exp(len);
        n = exp_q.size();
        k = $urandom_range(n - 1, 1);
        e = 8'($urandom);
        base = st_data.size();
        msg_len = 6'(len);
        wait_starts(base + k, 400 + 30 * k, "rnd_pre");
        send_rx(e);
        wait_starts(base + n + 1, 1500, "rnd_all");
        msg_len = 6'd0;
        ref_q = exp_q;
        ref_q.insert(k, e);
        for (int i = 0; i < n + 1; i++) check($sformatf("rnd_ch%0d", i), sd(base + i), 32'(ref_q[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_msg_sched.md
Name: uart_msg_sched

Overview:
- Parametrised successor to the board's UART test controller.
- Periodically transmits a programmable message from an internal buffer.
- Echoes received bytes through a small FIFO, so no echo byte is lost while a message is in flight.
- Sits between uart_rx/uart_tx cores and the top level; drives the tx core through a start/busy handshake instead of fixed wait counts.

Parameters:
- DW, 8, character width in bits.
- MSG_DEPTH, 32, message buffer entries (power of 2).
- ECHO_DEPTH, 4, echo FIFO entries (power of 2, >=2).
- PERIOD_CYCLES, 262144, idle clk cycles between the end of one message and the start of the next.
- GAP_CYCLES, 16, minimum clk cycles from one tx_start to the next.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received character.
- rx_data  in  DW  received character.
- tx_busy  in  1  tx core busy; rises the cycle after tx_start.
- tx_start  out  1  one-cycle strobe: tx_data is to be sent.
- tx_data  out  DW  character to send; held stable until the next tx_start.
- msg_we  in  1  message buffer write enable.
- msg_waddr  in  $clog2(MSG_DEPTH)  message buffer write address.
- msg_wdata  in  DW  message buffer write data.
- msg_len  in  $clog2(MSG_DEPTH)+1  number of characters per message; 0 disables message output.
- msg_active  out  1  high while a message is in progress (first start through last character done).
- echo_overflow  out  1  sticky; set when rx_valid arrives with the echo FIFO full.

Behaviour:
- Reset values: tx_start=0, tx_data=0, msg_active=0, echo_overflow=0; FIFO empty; period counter=0; message index=0; FSM=IDLE.
- Message buffer contents are not reset. A write to the buffer takes effect on the next cycle and may change characters not yet sent.
- Echo FIFO:
  - Push on rx_valid when not full.
  - Push while full drops the byte and sets echo_overflow; only rst clears it.
  - Pop only when the FSM issues an echo character.
  - A push and a pop in the same cycle on a full FIFO is legal and loses nothing.
- FSM states IDLE, ARB, ISSUE, GUARD, WAIT_TX.
  - IDLE: period counter increments each cycle. Go to ARB when the FIFO is non-empty, or when counter==PERIOD_CYCLES-1 and msg_len!=0. The counter saturates until the message starts and clears to 0 when it does.
  - ARB: echo has priority. If the FIFO is non-empty, select the FIFO head. Else, if msg_active or a period expired, select buf[index]. Else return to IDLE.
  - ISSUE: drive tx_data=selected character and tx_start=1 for exactly one cycle; pop the FIFO if echo was selected. Then go to GUARD.
  - GUARD: wait until GAP_CYCLES cycles have elapsed since tx_start; tx_busy is ignored here. Then go to WAIT_TX.
  - WAIT_TX: when tx_busy==0, go to ARB.
- Message sequencing:
  - msg_active rises in the ISSUE cycle of character 0.
  - index increments after each message character is issued.
  - After the character at index msg_len-1 completes (WAIT_TX exit): index=0, msg_active=0, period counter restarts.
  - Echo characters may interleave between message characters; the message resumes at its current index, never restarting or aborting.
- Latency: rx_valid at cycle N with the FSM in IDLE and the FIFO empty gives tx_start at cycle N+3 (push N+1, ARB N+2, ISSUE N+3).
- If msg_len changes mid-message and index>=msg_len, the message ends after the current character.
- rst mid-operation aborts immediately. The current tx core frame is not cancelled; the block waits for tx_busy==0 in IDLE before any new ARB.

Optional Feature:
- Macro: UART_MSG_CRLF_EN.
- Defined: after the last buffer character, two extra characters CR (8'h0D) then LF (8'h0A) are sent. Each goes through ISSUE/GUARD/WAIT_TX and may be interleaved with echoes. msg_active stays high until LF completes.
- Undefined: only the msg_len buffer characters are sent.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum.
  - Constants CHAR_CR=8'h0D and CHAR_LF=8'h0A.
  - Default DW, and a clog2 helper for synthesis tools lacking $clog2.
- One sub-module: uart_echo_fifo (parametrised DW/ECHO_DEPTH synchronous FIFO with full, empty, and overflow flag).

Test Plan:
- Program "Hello\n" (6 chars), msg_len=6, PERIOD_CYCLES=100; tx model holds busy for 20 cycles -> tx_data sequence 48 65 6C 6C 6F 0A; next message's first tx_start comes 100 cycles after the final busy falls.
- Mid-message (after 'e'), inject rx 8'h41 -> next tx_start carries 41, then 6C 6C 6F 0A resume; no character repeated or skipped.
- Inject 6 rx bytes back-to-back with tx busy, ECHO_DEPTH=4 -> first 4 echoed in order, echo_overflow=1 and stays 1 until rst.
- msg_len=0, no rx for 10*PERIOD_CYCLES -> tx_start never asserted.
- Assert rst during WAIT_TX with busy high -> outputs return to reset values next cycle; no tx_start until busy is low and a new trigger occurs.
- With UART_MSG_CRLF_EN, msg_len=2 "Hi" -> 48 69 0D 0A; msg_active falls after 0A completes.
